// File: rtl/dff_ram_master.sv
// Burst initiator for a dff_ram port: turns valid/ready read/write burst commands
// into one RAM beat per cycle and streams read data back through a 2-entry buffer.
module dff_ram_master #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 72,
  parameter int LEN_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              busy,
  output logic              ram_enb,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;

  logic [DATA_W-1:0] fifo_data_q [2];
  logic              fifo_last_q [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;

  logic       cmd_fire;
  logic       write_issue;
  logic       read_issue;
  logic       beat_issue;
  logic       last_beat;
  logic       push;
  logic       pop;
  logic [1:0] occupancy;
  logic       rd_room;

  assign cmd_fire    = cmd_valid & cmd_ready;
  assign last_beat   = (remaining_q == '0);
  assign push        = rst_n & inflight_q;
  assign pop         = rdata_valid & rdata_ready;

  // A read may issue only if its data is guaranteed a FIFO slot when it returns.
  assign occupancy   = count_q + 2'(inflight_q) - 2'(pop);
  assign rd_room     = (occupancy < 2'd2);

  assign beat_issue  = write_issue | read_issue;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          state_d = cmd_wr ? WRITE : READ;
        end
      end
      WRITE, READ: begin
        if (beat_issue && last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; everything is forced quiet while reset is held.
  always_comb begin
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    write_issue = 1'b0;
    read_issue  = 1'b0;
    ram_wr      = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE:  cmd_ready = 1'b1;
        WRITE: begin
          wdata_ready = 1'b1;
          ram_wr      = 1'b1;
          write_issue = wdata_valid;
        end
        READ:  read_issue = rd_room;
        default: ;
      endcase
    end
  end

  assign ram_enb  = beat_issue;
  assign ram_addr = cur_addr_q;
  assign ram_data = wdata;

  always_comb begin
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    inflight_d      = read_issue;
    inflight_last_d = last_beat;
    if (cmd_fire) begin
      cur_addr_d  = cmd_addr;
      remaining_d = cmd_len;
    end else if (beat_issue) begin
      cur_addr_d  = cur_addr_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end

  // Storage needs no reset; validity is carried by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ram_rdata;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

  assign rdata_valid = rst_n & (count_q != 2'd0);
  assign rdata       = fifo_data_q[rd_ptr_q];
  assign rdata_last  = rdata_valid & fifo_last_q[rd_ptr_q];
  assign busy        = rst_n & ((state_q != IDLE) | inflight_q | (count_q != 2'd0));

endmodule

// File: tb/tb_dff_ram_master.sv
// Directed bench for dff_ram_master with a behavioural dff_ram (1-cycle registered read)
// and a read-stream monitor; expected values are hand-computed constants.
module tb_dff_ram_master;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 72;
  localparam int LEN_W  = 2;

  localparam logic [DATA_W-1:0] DA = 72'hAA_0101_0202_0303_0404;
  localparam logic [DATA_W-1:0] DB = 72'hBB_1111_2222_3333_4444;
  localparam logic [DATA_W-1:0] DC = 72'hCC_5555_6666_7777_8888;
  localparam logic [DATA_W-1:0] DD = 72'hDD_9999_AAAA_BBBB_CCCC;
  localparam logic [DATA_W-1:0] DE = 72'hEE_1234_5678_9ABC_DEF0;
  localparam logic [DATA_W-1:0] DF = 72'hF0_0F0F_0F0F_0F0F_0F0F;
  localparam logic [DATA_W-1:0] DG = 72'h61_2323_4545_6767_8989;
  localparam logic [DATA_W-1:0] DH = 72'h77_ABAB_CDCD_EFEF_0101;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;
  logic              busy;
  logic              ram_enb;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_rdata = '0;

  int checkCnt = 0;
  int passCnt  = 0;

  logic [DATA_W-1:0] mem [4] = '{default: '0};
  int                ramWrites = 0;
  int                cycleCnt  = 0;
  logic [DATA_W-1:0] rxData [$];
  logic              rxLast [$];
  int                rxCycle [$];

  dff_ram_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata      (rdata),
    .rdata_last (rdata_last),
    .busy       (busy),
    .ram_enb    (ram_enb),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM plus a monitor that logs every accepted read beat.
  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (ram_enb) begin
      if (ram_wr) begin
        mem[ram_addr] <= ram_data;
        ramWrites     <= ramWrites + 1;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
    if (rst_n && rdata_valid && rdata_ready) begin
      rxData.push_back(rdata);
      rxLast.push_back(rdata_last);
      rxCycle.push_back(cycleCnt);
    end
  end

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      passCnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a command and returns just after the handshake edge.
  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [LEN_W-1:0] len);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    #1;
    while (!cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("cmd_accept_in_time", 72'(guard < 20), 72'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitBeats(input int n);
    int guard = 0;
    while (rxData.size() < n && guard < 30) begin
      tick();
      guard++;
    end
    checkOutput("beats_received", 72'(rxData.size()), 72'(n));
  endtask

  task automatic clearRx();
    rxData.delete();
    rxLast.delete();
    rxCycle.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] expRd [4];
    int                issues;
    int                wrStart;
    expRd = '{DA, DB, DC, DD};

    rst_n       = 1'b0;
    cmd_valid   = 1'b1;
    cmd_wr      = 1'b1;
    cmd_addr    = '0;
    cmd_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    rdata_ready = 1'b0;

    $display("[TB] reset with cmd_valid held");
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("rst_ram_enb", 72'(ram_enb), 72'd0);
      checkOutput("rst_cmd_ready", 72'(cmd_ready), 72'd0);
      checkOutput("rst_rdata_valid", 72'(rdata_valid), 72'd0);
      checkOutput("rst_busy", 72'(busy), 72'd0);
    end
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    tick();

    $display("[TB] write burst addr=2 len=3");
    applyStimulus(1'b1, 2'd2, 2'd3);
    for (int i = 0; i < 4; i++) begin
      wdata_valid = 1'b1;
      wdata       = expRd[i];
      #1;
      checkOutput("wr_ram_enb", 72'(ram_enb), 72'd1);
      checkOutput("wr_ram_wr", 72'(ram_wr), 72'd1);
      checkOutput("wr_ram_addr", 72'(ram_addr), 72'((2 + i) % 4));
      checkOutput("wr_ram_data", ram_data, expRd[i]);
      tick();
    end
    wdata = DH;
    #1;
    checkOutput("wr_idle_enb", 72'(ram_enb), 72'd0);
    checkOutput("wr_idle_wready", 72'(wdata_ready), 72'd0);
    checkOutput("wr_idle_cmd_ready", 72'(cmd_ready), 72'd1);
    wdata_valid = 1'b0;
    tick();
    checkOutput("mem2", mem[2], DA);
    checkOutput("mem3", mem[3], DB);
    checkOutput("mem0", mem[0], DC);
    checkOutput("mem1", mem[1], DD);

    $display("[TB] read burst addr=2 len=3 full rate");
    clearRx();
    rdata_ready = 1'b1;
    applyStimulus(1'b0, 2'd2, 2'd3);
    waitBeats(4);
    if (rxData.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("rd_data", rxData[i], expRd[i]);
        checkOutput("rd_last", 72'(rxLast[i]), 72'(i == 3));
      end
      checkOutput("rd_back_to_back", 72'(rxCycle[3] - rxCycle[0]), 72'd3);
    end
    tick();
    tick();
    checkOutput("rd_busy_done", 72'(busy), 72'd0);

    $display("[TB] read burst with backpressure");
    clearRx();
    rdata_ready = 1'b0;
    applyStimulus(1'b0, 2'd2, 2'd3);
    issues = 0;
    for (int i = 0; i < 5; i++) begin
      if (ram_enb) issues++;
      tick();
    end
    checkOutput("bp_issue_count", 72'(issues), 72'd2);
    checkOutput("bp_valid_held", 72'(rdata_valid), 72'd1);
    checkOutput("bp_head_data", rdata, DA);
    checkOutput("bp_busy", 72'(busy), 72'd1);
    rdata_ready = 1'b1;
    waitBeats(4);
    if (rxData.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("bp_data", rxData[i], expRd[i]);
        checkOutput("bp_last", 72'(rxLast[i]), 72'(i == 3));
      end
    end

    $display("[TB] read addr=0 then write addr=0");
    clearRx();
    wrStart = ramWrites;
    applyStimulus(1'b0, 2'd0, 2'd0);
    wdata_valid = 1'b1;
    wdata       = DE;
    applyStimulus(1'b1, 2'd0, 2'd0);
    checkOutput("rw_ram_enb", 72'(ram_enb), 72'd1);
    checkOutput("rw_ram_wr", 72'(ram_wr), 72'd1);
    checkOutput("rw_ram_addr", 72'(ram_addr), 72'd0);
    tick();
    wdata_valid = 1'b0;
    waitBeats(1);
    if (rxData.size() == 1) begin
      checkOutput("rw_old_data", rxData[0], DC);
      checkOutput("rw_last", 72'(rxLast[0]), 72'd1);
    end
    checkOutput("rw_mem0_new", mem[0], DE);
    checkOutput("rw_write_count", 72'(ramWrites - wrStart), 72'd1);

    $display("[TB] reset in the middle of a write burst");
    wrStart = ramWrites;
    applyStimulus(1'b1, 2'd1, 2'd3);
    wdata_valid = 1'b1;
    wdata       = DF;
    tick();
    wdata = DG;
    tick();
    wdata = DH;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_enb", 72'(ram_enb), 72'd0);
    checkOutput("mid_rst_cmd_ready", 72'(cmd_ready), 72'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_cmd_ready", 72'(cmd_ready), 72'd1);
    checkOutput("post_rst_busy", 72'(busy), 72'd0);
    checkOutput("post_rst_rvalid", 72'(rdata_valid), 72'd0);
    checkOutput("post_rst_wready", 72'(wdata_ready), 72'd0);
    issues = 0;
    for (int i = 0; i < 3; i++) begin
      if (ram_enb) issues++;
      tick();
    end
    checkOutput("post_rst_no_access", 72'(issues), 72'd0);
    wdata_valid = 1'b0;
    checkOutput("mid_rst_write_count", 72'(ramWrites - wrStart), 72'd2);
    checkOutput("mid_rst_mem1", mem[1], DF);
    checkOutput("mid_rst_mem2", mem[2], DG);
    checkOutput("mid_rst_mem3", mem[3], DB);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
